burst_mem_responder: RTL

BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

---
 rtl/burst_mem_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: 256-bit line memory model answering four-beat
// 64-bit read/write bursts after a fixed request-to-data latency.
//
// state | meaning
// IDLE  | waiting for pmem_read/pmem_write; accepts on the first edge it sees one
// WAIT  | latency countdown before the burst
// BURST | presenting/collecting beats 0..3, one per cycle
// DONE  | one quiet cycle after the last beat
module burst_mem_responder #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  logic [63:0] pmem_wdata,
    output logic [63:0] pmem_rdata,
    output logic        pmem_resp,
    output logic        busy,
    output logic        protocol_err
);

    localparam int IW = $clog2(DEPTH_LINES);
    localparam logic [3:0] LAT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    beat_cnt;
    logic [3:0]    lat_cnt;
    logic          op_write;
    logic [IW-1:0] idx_q;
    logic [255:0]  line_q;
    logic [255:0]  mem [DEPTH_LINES];

    logic          req_any;
    logic [IW-1:0] addr_idx;
    logic [1:0]    next_beat;
    logic          wr_en;
    logic          unused_addr_bits;

    assign req_any   = pmem_read | pmem_write;
    assign addr_idx  = pmem_address[5 +: IW];
    assign next_beat = beat_cnt + 2'd1;
    assign busy      = (state != S_IDLE);
    assign unused_addr_bits = ^{pmem_address[31:5+IW], pmem_address[4:0]};

    // A write beat is committed on the edge that ends its resp cycle, unless
    // the initiator has dropped the request (abort leaves that beat unwritten).
    assign wr_en = (state == S_BURST) && pmem_resp && op_write && req_any;

    // Control FSM: pmem_resp/pmem_rdata are registered, so each beat appears
    // one cycle after the edge that issues it; beat_cnt tracks the beat on the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            beat_cnt     <= 2'd0;
            lat_cnt      <= 4'd0;
            op_write     <= 1'b0;
            idx_q        <= '0;
            line_q       <= '0;
            pmem_resp    <= 1'b0;
            pmem_rdata   <= 64'd0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        op_write <= pmem_write & ~pmem_read;
                        idx_q    <= addr_idx;
                        line_q   <= mem[addr_idx];
                        beat_cnt <= 2'd0;
                        if (pmem_read && pmem_write) protocol_err <= 1'b1;
                        if (LATENCY == 1) begin
                            state   <= S_BURST;
                            lat_cnt <= 4'd0;
                        end else begin
                            state   <= S_WAIT;
                            lat_cnt <= LAT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req_any) begin
                        state        <= S_IDLE;
                        lat_cnt      <= 4'd0;
                        protocol_err <= 1'b1;
                    end else if (lat_cnt == 4'd0) begin
                        state <= S_BURST;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                S_BURST: begin
                    if (!req_any) begin
                        state        <= S_IDLE;
                        beat_cnt     <= 2'd0;
                        pmem_resp    <= 1'b0;
                        pmem_rdata   <= 64'd0;
                        protocol_err <= 1'b1;
                    end else if (!pmem_resp) begin
                        pmem_resp  <= 1'b1;
                        pmem_rdata <= line_q[63:0];
                    end else if (beat_cnt == 2'd3) begin
                        state      <= S_DONE;
                        beat_cnt   <= 2'd0;
                        pmem_resp  <= 1'b0;
                        pmem_rdata <= 64'd0;
                    end else begin
                        beat_cnt   <= next_beat;
                        pmem_rdata <= line_q[{next_beat, 6'd0} +: 64];
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Backing store: no reset, contents survive rst and are written beat by beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx_q][{beat_cnt, 6'd0} +: 64] <= pmem_wdata;
        end
    end

endmodule
